// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with a zero latency write-to-read
// bypass, an externally supplied PC index, and a per-register scoreboard
// that raises a stall when a used read port depends on a pending writeback.
// Optional feature: define REGFILE_WAW_CHECK_EN to build the sticky WAW
// hazard flag on err. When it is undefined, err is tied low.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NRD    = 3,
  parameter int PC_IDX = 15,
  parameter int PC_ADJ = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    wa,
  input  logic [DATA_W-1:0]    wd,
  input  logic [NRD*ADDR_W-1:0] ra,
  input  logic [NRD-1:0]       ra_en,
  output logic [NRD*DATA_W-1:0] rd,
  input  logic [DATA_W-1:0]    pc_in,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_dst,
  output logic [(2**ADDR_W)-1:0] busy,
  output logic                 stall,
  output logic                 err
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A   = ADDR_W'(PC_IDX);
  localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] ADJ_D  = DATA_W'(PC_ADJ);

  logic [DATA_W-1:0] regs_r [NREG];
  logic [NREG-1:0]   busy_r;
  logic [NREG-1:0]   busy_nxt_s;
  logic [ADDR_W-1:0] ra_s [NRD];
  logic [NRD*DATA_W-1:0] rd_s;
  logic              stall_s;
  logic              wr_ok_s;

  // Writes to the hard-wired zero index and to the PC index are discarded.
  assign wr_ok_s = we && (wa != ZERO_A) && (wa != PC_A);

  // Register storage: reset clears all entries, otherwise take the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NREG; n++) begin
        regs_r[n] <= {DATA_W{1'b0}};
      end
    end else if (wr_ok_s) begin
      regs_r[wa] <= wd;
    end
  end

  // Split the packed read-address bus into one address per port.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      ra_s[i] = ra[i*ADDR_W +: ADDR_W];
    end
  end

  // Read mux per port (zero, PC, bypass, storage) and stall qualification.
  always_comb begin
    rd_s    = {(NRD*DATA_W){1'b0}};
    stall_s = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      if (ra_s[i] == ZERO_A) begin
        rd_s[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end else if (ra_s[i] == PC_A) begin
        rd_s[i*DATA_W +: DATA_W] = pc_in - ADJ_D;
      end else if (we && (wa == ra_s[i])) begin
        rd_s[i*DATA_W +: DATA_W] = wd;
      end else begin
        rd_s[i*DATA_W +: DATA_W] = regs_r[ra_s[i]];
      end
      // A register being written back this cycle is bypassed, so no stall.
      if (ra_en[i] && busy_r[ra_s[i]] && !(we && (wa == ra_s[i]))) begin
        stall_s = 1'b1;
      end else begin
        stall_s = stall_s;
      end
    end
  end

  // Scoreboard next state: writeback clears first, a new issue then sets,
  // so the issuing instruction owns the register when both hit together.
  always_comb begin
    busy_nxt_s = busy_r;
    if (we) begin
      busy_nxt_s[wa] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (issue_valid) begin
      busy_nxt_s[issue_dst] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    busy_nxt_s[0]      = 1'b0;
    busy_nxt_s[PC_IDX] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= {NREG{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

`ifdef REGFILE_WAW_CHECK_EN
  logic err_r;
  logic waw_s;

  // WAW hazard: issuing to a register that is still pending and not being
  // retired by a writeback in the same cycle.
  always_comb begin
    if (issue_valid && (issue_dst != ZERO_A) && (issue_dst != PC_A) &&
        busy_r[issue_dst] && !(we && (wa == issue_dst))) begin
      waw_s = 1'b1;
    end else begin
      waw_s = 1'b0;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | waw_s;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign rd    = rd_s;
  assign stall = stall_s;
  assign busy  = busy_r;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: reset sweep, directed vector table,
// hand sequences for WAW and mid-sequence reset, then random stimulus
// checked against an array-based reference model.
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic        we;
  logic [3:0]  wa;
  logic [31:0] wd;
  logic [11:0] ra;
  logic [2:0]  ra_en;
  logic [95:0] rd;
  logic [31:0] pc_in;
  logic        issue_valid;
  logic [3:0]  issue_dst;
  logic [15:0] busy;
  logic        stall;
  logic        err;

  int checks = 0;
  int errors = 0;

`ifdef REGFILE_WAW_CHECK_EN
  localparam logic WAW_ON = 1'b1;
`else
  localparam logic WAW_ON = 1'b0;
`endif

  regfile_sb dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra),
    .ra_en(ra_en), .rd(rd), .pc_in(pc_in), .issue_valid(issue_valid),
    .issue_dst(issue_dst), .busy(busy), .stall(stall), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [31:0] mreg [16];
  logic [15:0] mbusy;
  logic        merr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic [3:0] a);
    if (a == 4'd0) return 32'd0;
    if (a == 4'd15) return pc_in - 32'd1;
    if (we && wa == a) return wd;
    return mreg[a];
  endfunction

  function automatic logic mstall();
    logic s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic [3:0] a = ra[i*4 +: 4];
      if (ra_en[i] && mbusy[a] && !(we && wa == a)) s = 1'b1;
    end
    return s;
  endfunction

  task automatic mupdate();
    if (rst) begin
      for (int n = 0; n < 16; n++) mreg[n] = 32'd0;
      mbusy = 16'd0;
      merr  = 1'b0;
    end else begin
      logic valid_dst = issue_valid && issue_dst != 4'd0 && issue_dst != 4'd15;
      if (WAW_ON && valid_dst && mbusy[issue_dst] && !(we && wa == issue_dst)) merr = 1'b1;
      if (we && wa != 4'd0 && wa != 4'd15) mreg[wa] = wd;
      if (we) mbusy[wa] = 1'b0;
      if (valid_dst) mbusy[issue_dst] = 1'b1;
    end
  endtask

  // One clock: compare combinational outputs and state against the model,
  // cross the edge, advance the model, return at the falling edge.
  task automatic cycle();
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("rd_p%0d", i), rd[i*32 +: 32], mread(ra[i*4 +: 4]));
    chk("stall", {31'd0, stall}, {31'd0, mstall()});
    chk("busy", {16'd0, busy}, {16'd0, mbusy});
    chk("err", {31'd0, err}, {31'd0, merr});
    @(posedge clk);
    mupdate();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; we = 1'b0; wa = 4'd0; wd = 32'd0; ra = 12'd0; ra_en = 3'd0;
    issue_valid = 1'b0; issue_dst = 4'd0;
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [11:0] ra;
    logic [2:0]  en;
    logic [31:0] pc;
    logic        iv;
    logic [3:0]  dst;
    logic [31:0] x_rd0;
    logic        x_stall;
    logic [15:0] x_busy;
  } vec_t;

  vec_t tbl [14];

  initial begin
    for (int n = 0; n < 16; n++) mreg[n] = 32'd0;
    mbusy = 16'd0;
    merr  = 1'b0;
    idle();
    pc_in = 32'h100;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset sweep: every index on every port.
    for (int a = 0; a < 16; a++) begin
      logic [3:0] a4 = a[3:0];
      logic [31:0] exp_v = (a == 15) ? 32'h0000_00FF : 32'd0;
      ra = {a4, a4, a4};
      #1;
      for (int i = 0; i < 3; i++)
        chk($sformatf("reset_rd_p%0d_a%0d", i, a), rd[i*32 +: 32], exp_v);
    end
    chk("reset_busy", {16'd0, busy}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);

    // Directed vectors: {inputs, expected rd0/stall before edge, busy after}.
    tbl[0]  = '{1'b1, 4'd3,  32'hDEADBEEF, {4'd0, 4'd0, 4'd3},  3'b000, 32'h100, 1'b0, 4'd0, 32'hDEADBEEF, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 4'd0,  32'd0,        {4'd0, 4'd0, 4'd3},  3'b000, 32'h100, 1'b0, 4'd0, 32'hDEADBEEF, 1'b0, 16'h0000};
    tbl[2]  = '{1'b1, 4'd0,  32'h55,       {4'd0, 4'd0, 4'd0},  3'b000, 32'h100, 1'b0, 4'd0, 32'd0,        1'b0, 16'h0000};
    tbl[3]  = '{1'b1, 4'd15, 32'h66,       {4'd0, 4'd0, 4'd15}, 3'b000, 32'h100, 1'b0, 4'd0, 32'hFF,       1'b0, 16'h0000};
    tbl[4]  = '{1'b0, 4'd0,  32'd0,        {4'd0, 4'd0, 4'd0},  3'b000, 32'h100, 1'b0, 4'd0, 32'd0,        1'b0, 16'h0000};
    tbl[5]  = '{1'b0, 4'd0,  32'd0,        {4'd0, 4'd0, 4'd15}, 3'b000, 32'h0,   1'b0, 4'd0, 32'hFFFFFFFF, 1'b0, 16'h0000};
    tbl[6]  = '{1'b0, 4'd0,  32'd0,        {4'd0, 4'd0, 4'd0},  3'b000, 32'h100, 1'b1, 4'd5, 32'd0,        1'b0, 16'h0020};
    tbl[7]  = '{1'b0, 4'd0,  32'd0,        {4'd0, 4'd5, 4'd5},  3'b010, 32'h100, 1'b0, 4'd0, 32'd0,        1'b1, 16'h0020};
    tbl[8]  = '{1'b1, 4'd5,  32'd7,        {4'd0, 4'd5, 4'd5},  3'b010, 32'h100, 1'b0, 4'd0, 32'd7,        1'b0, 16'h0000};
    tbl[9]  = '{1'b0, 4'd0,  32'd0,        {4'd0, 4'd0, 4'd5},  3'b000, 32'h100, 1'b1, 4'd6, 32'd7,        1'b0, 16'h0040};
    tbl[10] = '{1'b1, 4'd6,  32'd9,        {4'd0, 4'd0, 4'd6},  3'b001, 32'h100, 1'b1, 4'd6, 32'd9,        1'b0, 16'h0040};
    tbl[11] = '{1'b0, 4'd0,  32'd0,        {4'd0, 4'd0, 4'd6},  3'b000, 32'h100, 1'b0, 4'd0, 32'd9,        1'b0, 16'h0040};
    tbl[12] = '{1'b0, 4'd0,  32'd0,        {4'd0, 4'd0, 4'd6},  3'b001, 32'h100, 1'b0, 4'd0, 32'd9,        1'b1, 16'h0040};
    tbl[13] = '{1'b0, 4'd0,  32'd0,        {4'd0, 4'd0, 4'd15}, 3'b001, 32'h100, 1'b1, 4'd15, 32'hFF,      1'b0, 16'h0040};

    for (int k = 0; k < 14; k++) begin
      we = tbl[k].we; wa = tbl[k].wa; wd = tbl[k].wd; ra = tbl[k].ra;
      ra_en = tbl[k].en; pc_in = tbl[k].pc; issue_valid = tbl[k].iv;
      issue_dst = tbl[k].dst;
      #1;
      chk($sformatf("vec%0d_rd0", k), rd[31:0], tbl[k].x_rd0);
      chk($sformatf("vec%0d_stall", k), {31'd0, stall}, {31'd0, tbl[k].x_stall});
      cycle();
      chk($sformatf("vec%0d_busy", k), {16'd0, busy}, {16'd0, tbl[k].x_busy});
    end
    chk("vec_err", {31'd0, err}, 32'd0);

    // WAW: two issues to r4 without writeback.
    idle(); rst = 1'b1; cycle();
    idle(); issue_valid = 1'b1; issue_dst = 4'd4; cycle();
    chk("waw_first", {31'd0, err}, 32'd0);
    cycle();
    chk("waw_second", {31'd0, err}, {31'd0, WAW_ON});
    idle(); cycle(); cycle();
    chk("waw_sticky", {31'd0, err}, {31'd0, WAW_ON});

    // Reset has priority over a simultaneous write and issue.
    idle(); we = 1'b1; wa = 4'd3; wd = 32'h1234; cycle();
    rst = 1'b1; we = 1'b1; wa = 4'd3; wd = 32'h5678;
    issue_valid = 1'b1; issue_dst = 4'd7; cycle();
    idle(); ra = {4'd0, 4'd7, 4'd3}; ra_en = 3'b111;
    #1;
    chk("rstpri_rd0", rd[31:0], 32'd0);
    chk("rstpri_busy", {16'd0, busy}, 32'd0);
    chk("rstpri_stall", {31'd0, stall}, 32'd0);
    chk("rstpri_err", {31'd0, err}, 32'd0);
    cycle();

    // Random stimulus against the model.
    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom_range(0, 79) == 0);
      we          = $urandom_range(0, 1);
      wa          = 4'($urandom_range(0, 15));
      wd          = $urandom;
      ra          = 12'($urandom);
      ra_en       = 3'($urandom_range(0, 7));
      pc_in       = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      issue_valid = $urandom_range(0, 1);
      issue_dst   = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
